// File: rtl/mem_bus_arbiter_if.sv
// Requester, memory and snoop signals of the two-port memory bus arbiter.
// The slave modport is the arbiter side; master is the requester/memory side.
interface mem_bus_arbiter_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 4
);
   logic                     req0;
   logic                     req1;
   logic                     wren0;
   logic                     wren1;
   logic [ADDR_W-1:0]        addr0;
   logic [ADDR_W-1:0]        addr1;
   logic [DATA_W-1:0]        wdata0;
   logic [DATA_W-1:0]        wdata1;
   logic [1:0]               gnt;
   logic [1:0]               ack;
   logic [DATA_W-1:0]        rdata;
   logic                     busy;
   logic [ADDR_W-1:0]        mem_addr;
   logic [DATA_W-1:0]        mem_data;
   logic                     mem_wren;
   logic [ADDR_W+DATA_W-1:0] mem_q;
   logic                     snoop_valid;
   logic                     snoop_wr;
   logic                     snoop_src;
   logic [ADDR_W-1:0]        snoop_addr;

   modport slave (
      input  req0, req1, wren0, wren1, addr0, addr1, wdata0, wdata1, mem_q,
      output gnt, ack, rdata, busy, mem_addr, mem_data, mem_wren,
             snoop_valid, snoop_wr, snoop_src, snoop_addr
   );

   modport master (
      output req0, req1, wren0, wren1, addr0, addr1, wdata0, wdata1, mem_q,
      input  gnt, ack, rdata, busy, mem_addr, mem_data, mem_wren,
             snoop_valid, snoop_wr, snoop_src, snoop_addr
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving two requesters access to a memory with a registered {addr,data} output.
// Define MEM_BUS_SNOOP_EN to broadcast each issued transaction on the snoop outputs.
module mem_bus_arbiter #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 4
) (
   input logic              clock,
   input logic              reset,
   mem_bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic              take;
   logic              sel;
   logic              last_q;
   logic [1:0]        gnt_q;
   logic [1:0]        ack_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] rdata_q;
   logic              mem_wren_q;
   logic              echo_err_q;
   logic              unused_echo_err;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // sel is the winning requester index; on a tie the one not granted last wins.
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      sel     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req0 || bus.req1) begin
               take    = 1'b1;
               sel     = bus.req1 && (!bus.req0 || !last_q);
               state_d = StIssue;
            end
         end
         StIssue: state_d = StWait;
         StWait:  state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_q     <= 1'b1;
         gnt_q      <= '0;
         ack_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         rdata_q    <= '0;
         mem_wren_q <= 1'b0;
         echo_err_q <= 1'b0;
      end else begin
         mem_wren_q <= 1'b0;
         if (take) begin
            last_q     <= sel;
            gnt_q      <= sel ? 2'b10 : 2'b01;
            addr_q     <= sel ? bus.addr1 : bus.addr0;
            data_q     <= sel ? bus.wdata1 : bus.wdata0;
            mem_wren_q <= sel ? bus.wren1 : bus.wren0;
         end
         if (state_q == StWait) begin
            rdata_q    <= bus.mem_q[DATA_W-1:0];
            echo_err_q <= (bus.mem_q[ADDR_W+DATA_W-1:DATA_W] != addr_q);
            ack_q      <= gnt_q;
         end
         if (state_q == StResp) begin
            ack_q <= '0;
            gnt_q <= '0;
         end
      end
   end

   // The echo check is a debug observable only; it never changes sequencing or rdata.
   assign unused_echo_err = echo_err_q;

   assign bus.gnt      = gnt_q;
   assign bus.ack      = ack_q;
   assign bus.rdata    = rdata_q;
   assign bus.busy     = (state_q != StIdle);
   assign bus.mem_addr = addr_q;
   assign bus.mem_data = data_q;
   assign bus.mem_wren = mem_wren_q;

`ifdef MEM_BUS_SNOOP_EN
   logic              snoop_valid_q;
   logic              snoop_wr_q;
   logic              snoop_src_q;
   logic [ADDR_W-1:0] snoop_addr_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         snoop_valid_q <= 1'b0;
         snoop_wr_q    <= 1'b0;
         snoop_src_q   <= 1'b0;
         snoop_addr_q  <= '0;
      end else begin
         snoop_valid_q <= take;
         if (take) begin
            snoop_wr_q   <= sel ? bus.wren1 : bus.wren0;
            snoop_src_q  <= sel;
            snoop_addr_q <= sel ? bus.addr1 : bus.addr0;
         end
      end
   end

   assign bus.snoop_valid = snoop_valid_q;
   assign bus.snoop_wr    = snoop_wr_q;
   assign bus.snoop_src   = snoop_src_q;
   assign bus.snoop_addr  = snoop_addr_q;
`else
   assign bus.snoop_valid = 1'b0;
   assign bus.snoop_wr    = 1'b0;
   assign bus.snoop_src   = 1'b0;
   assign bus.snoop_addr  = '0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and random transactions against a transaction-level model of the arbiter and memory.
// Build with MEM_BUS_SNOOP_EN defined to also check the snoop broadcast.
module tb_mem_bus_arbiter;

   logic clock;
   logic reset;
   logic mem_load;

   mem_bus_arbiter_if #(.ADDR_W(4), .DATA_W(4)) bus ();

   mem_bus_arbiter #(.ADDR_W(4), .DATA_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [3:0] init_val(input logic [3:0] a);
      return (a == 4'd5) ? 4'b0101 : 4'(a * 3 + 1);
   endfunction

   // Memory with registered {addr,data} output; write data is echoed on the write cycle.
   logic [3:0] mem [16];
   always @(posedge clock) begin
      if (mem_load) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_val(4'(i));
      end else if (bus.mem_wren) begin
         mem[bus.mem_addr] <= bus.mem_data;
      end
      bus.mem_q <= {bus.mem_addr, bus.mem_wren ? bus.mem_data : mem[bus.mem_addr]};
   end

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [3:0]  ref_mem [16];
   logic        ref_last;
   time         t_ack;
   time         t_prev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic drive(input logic r0, r1, w0, w1, input logic [3:0] a0, a1, d0, d1);
      bus.req0 = r0;  bus.req1 = r1;
      bus.wren0 = w0; bus.wren1 = w1;
      bus.addr0 = a0; bus.addr1 = a1;
      bus.wdata0 = d0; bus.wdata1 = d1;
   endtask

   // Called at a falling edge with the DUT idle; returns at the falling edge of the next idle cycle.
   task automatic run_txn(input logic r0, r1, w0, w1, input logic [3:0] a0, a1, d0, d1,
                          input logic drop);
      logic       win;
      logic       wr;
      logic [3:0] a;
      logic [3:0] d;
      logic [3:0] rd;
      logic [1:0] oh;
      drive(r0, r1, w0, w1, a0, a1, d0, d1);
      if (r0 && r1) win = !ref_last;
      else          win = r1;
      ref_last = win;
      oh = win ? 2'b10 : 2'b01;
      wr = win ? w1 : w0;
      a  = win ? a1 : a0;
      d  = win ? d1 : d0;
      rd = wr ? d : ref_mem[a];
      if (wr) ref_mem[a] = d;

      @(negedge clock);
      chk("issue_gnt", 32'(bus.gnt), 32'(oh));
      chk("issue_busy", 32'(bus.busy), 32'd1);
      chk("issue_mem_wren", 32'(bus.mem_wren), 32'(wr));
      chk("issue_mem_addr", 32'(bus.mem_addr), 32'(a));
      chk("issue_mem_data", 32'(bus.mem_data), 32'(d));
      chk("issue_ack", 32'(bus.ack), 32'd0);
`ifdef MEM_BUS_SNOOP_EN
      chk("snoop_valid", 32'(bus.snoop_valid), 32'd1);
      chk("snoop_addr", 32'(bus.snoop_addr), 32'(a));
      chk("snoop_wr", 32'(bus.snoop_wr), 32'(wr));
      chk("snoop_src", 32'(bus.snoop_src), 32'(win));
`else
      chk("snoop_off", 32'({bus.snoop_valid, bus.snoop_wr, bus.snoop_src, bus.snoop_addr}),
          32'd0);
`endif
      if (drop) begin
         bus.req0 = 1'b0;
         bus.req1 = 1'b0;
      end

      @(negedge clock);
      chk("wait_mem_wren", 32'(bus.mem_wren), 32'd0);
      chk("wait_mem_addr", 32'(bus.mem_addr), 32'(a));
      chk("wait_ack", 32'(bus.ack), 32'd0);
      chk("wait_busy", 32'(bus.busy), 32'd1);
      chk("wait_snoop_valid", 32'(bus.snoop_valid), 32'd0);

      @(negedge clock);
      t_ack = $time;
      chk("resp_ack", 32'(bus.ack), 32'(oh));
      chk("resp_rdata", 32'(bus.rdata), 32'(rd));
      chk("resp_gnt", 32'(bus.gnt), 32'(oh));
      chk("resp_mem_wren", 32'(bus.mem_wren), 32'd0);

      @(negedge clock);
      chk("idle_ack", 32'(bus.ack), 32'd0);
      chk("idle_gnt", 32'(bus.gnt), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk(tag, 32'({bus.gnt, bus.ack, bus.rdata, bus.busy, bus.mem_addr, bus.mem_data,
                    bus.mem_wren, bus.snoop_valid, bus.snoop_wr, bus.snoop_src,
                    bus.snoop_addr}), 32'd0);
   endtask

   // Starts a transaction and resets during its WAIT cycle; no ack may ever follow.
   task automatic abort_txn(input logic who, input logic wr, input logic [3:0] a, d);
      drive(!who, who, wr, wr, a, a, d, d);
      @(negedge clock);
      if (wr) ref_mem[a] = d;
      @(negedge clock);
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      @(negedge clock);
      check_all_zero("abort_zero");
      reset = 1'b0;
      ref_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("abort_no_ack", 32'({bus.ack, bus.busy}), 32'd0);
      end
   endtask

   initial begin
      logic [3:0] ra0, ra1, rd0, rd1;
      logic       rr0, rr1, rw0, rw1, rdrop;
      reset    = 1'b1;
      mem_load = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(4'(i));
      ref_last = 1'b1;
      repeat (2) @(negedge clock);
      check_all_zero("reset_state");
      mem_load = 1'b0;
      reset    = 1'b0;

      // Read of preloaded m[5], write 0011 to 9 and read it back, snoop-visible write to 14.
      run_txn(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0);
      run_txn(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd9, 4'd0, 4'b0011, 1'b0);
      run_txn(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 4'd0, 4'd0, 1'b1);
      run_txn(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd14, 4'd0, 4'd6, 1'b0);

      // Both requesters held from reset: alternate grants, acks four cycles apart.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      ref_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         t_prev = t_ack;
         run_txn(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd12, 4'd0, 4'd0, 1'b0);
         if (i > 0) chk("ack_spacing", 32'(t_ack - t_prev), 32'd40);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

      // Aborted read, then an aborted write whose memory update must survive.
      abort_txn(1'b0, 1'b0, 4'd5, 4'd0);
      abort_txn(1'b1, 1'b1, 4'd2, 4'hE);
      run_txn(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd5, 4'd0, 4'd0, 1'b1);

      for (int i = 0; i < 24; i++) begin
         rr0 = 1'($urandom);
         rr1 = 1'($urandom);
         if (!rr0 && !rr1) rr1 = 1'b1;
         rw0 = 1'($urandom);
         rw1 = 1'($urandom);
         ra0 = 4'($urandom);
         ra1 = 4'($urandom);
         rd0 = 4'($urandom);
         rd1 = 4'($urandom);
         rdrop = 1'($urandom);
         run_txn(rr0, rr1, rw0, rw1, ra0, ra1, rd0, rd1, rdrop);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
